// File: rtl/dmem_pkg.sv
// Shared types and store-lane helpers for the MEM-stage data cache responder.
// Byte k of a word lives at bits [31-8k -: 8]; wstrb bit 3 enables byte 0.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2,
    ST_WR_DONE = 2'd3
  } dmem_state_e;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  // Number of bytes a store size encodes (1..4).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return (size == SZ_WORD) ? 3'd4 : {1'b0, size};
  endfunction

  // Left-justify N enables at byte 0, then slide to the offset; lanes past byte 3 fall off.
  function automatic logic [STRB_W-1:0] store_strb(input logic [1:0] off, input logic [1:0] size);
    logic [2:0] pad;
    pad = 3'd4 - size_bytes(size);
    return (4'hF << pad) >> off;
  endfunction

  // Same trick on data: MSB of the N-byte value lands on byte 'off'.
  function automatic logic [WORD_W-1:0] store_data(input logic [1:0] off, input logic [1:0] size,
                                                   input logic [WORD_W-1:0] data);
    logic [5:0] pad_bits;
    logic [4:0] off_bits;
    pad_bits = {3'd4 - size_bytes(size), 3'b000};
    off_bits = {off, 3'b000};
    return (data << pad_bits) >> off_bits;
  endfunction

  // Expand byte enables into a bit mask.
  function automatic logic [WORD_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/dmem_cache_responder_if.sv
// MEM-stage request/response bundle plus backing-memory req/ack bus.
// slave  : the cache responder's view.
// master : the environment's view (pipeline + memory model).
interface dmem_cache_responder_if;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] read_hits;
  logic [31:0] read_misses;

  modport slave (
    input  data_address_2DM, data_write_2DM, data_write_size_2DM, MemRead_2DM, MemWrite_2DM,
    input  mem_ack, mem_rdata,
    output data_read_fDM, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output read_hits, read_misses
  );

  modport master (
    output data_address_2DM, data_write_2DM, data_write_size_2DM, MemRead_2DM, MemWrite_2DM,
    output mem_ack, mem_rdata,
    input  data_read_fDM, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  read_hits, read_misses
  );
endinterface

// File: rtl/dmem_store_align.sv
// Combinational store aligner: (offset, size, right-justified data) -> byte enables
// and byte-lane-positioned write data.
//   offset  : addr[1:0]
//   size    : SZ_* encoding
//   data    : right-justified store data
//   wstrb_c : byte enables (bit 3 = byte 0)
//   wdata_c : lane-positioned data, unstrobed lanes zero
module dmem_store_align
  import dmem_pkg::*;
(
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic [WORD_W-1:0] data,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [WORD_W-1:0] wdata_c
);
  assign wstrb_c = store_strb(offset, size);
  assign wdata_c = store_data(offset, size, data);
endmodule

// File: rtl/dmem_cache_responder.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate data cache that
// answers MEM-stage loads/stores and drives the pipeline stall.
//   CLK, RESET : clock, async active-high reset
//   bus        : MEM-stage strobes/data, read data, stall, backing-memory req/ack,
//                read hit/miss counters
module dmem_cache_responder
  import dmem_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_BITS  = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dmem_cache_responder_if.slave  bus
);
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_BITS - INDEX_BITS - 2;

  dmem_state_e          state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_W-1:0]    mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]    mem_wstrb_q, mem_wstrb_d;
  logic [WORD_W-1:0]    read_hits_q, read_hits_d;
  logic [WORD_W-1:0]    read_misses_q, read_misses_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [WORD_W-1:0]    data_q [LINES];

  logic                  line_we;
  logic [INDEX_BITS-1:0] line_idx;
  logic [TAG_W-1:0]      line_tag;
  logic [WORD_W-1:0]     line_data;

  logic                  stall_c;
  logic [WORD_W-1:0]     rdata_c;
  logic [STRB_W-1:0]     al_wstrb_c;
  logic [WORD_W-1:0]     al_wdata_c;

  logic [ADDR_BITS-1:0]  req_addr;
  logic [INDEX_BITS-1:0] req_idx, own_idx;
  logic [TAG_W-1:0]      req_tag, own_tag;
  logic                  req_hit, own_hit;

  dmem_store_align u_align (
    .offset  (bus.data_address_2DM[1:0]),
    .size    (bus.data_write_size_2DM),
    .data    (bus.data_write_2DM),
    .wstrb_c (al_wstrb_c),
    .wdata_c (al_wdata_c)
  );

  // Lookup for the incoming request and for the outstanding (latched) one.
  assign req_addr = bus.data_address_2DM[ADDR_BITS-1:0];
  assign req_idx  = req_addr[INDEX_BITS+1:2];
  assign req_tag  = req_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign own_idx  = mem_addr_q[INDEX_BITS+1:2];
  assign own_tag  = mem_addr_q[ADDR_BITS-1:INDEX_BITS+2];
  assign own_hit  = valid_q[own_idx] && (tag_q[own_idx] == own_tag);

  // Next-state, request registers, line updates and combinational response.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    read_hits_d   = read_hits_q;
    read_misses_d = read_misses_q;
    valid_d       = valid_q;
    line_we       = 1'b0;
    line_idx      = own_idx;
    line_tag      = own_tag;
    line_data     = bus.mem_rdata;
    stall_c       = 1'b0;
    rdata_c       = '0;

    case (state_q)
      ST_IDLE: begin
        rdata_c = req_hit ? data_q[req_idx] : '0;
        if (bus.MemWrite_2DM) begin
          stall_c     = 1'b1;
          state_d     = ST_WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = WORD_W'({req_addr[ADDR_BITS-1:2], 2'b00});
          mem_wdata_d = al_wdata_c;
          mem_wstrb_d = al_wstrb_c;
        end else if (bus.MemRead_2DM) begin
          if (req_hit) begin
            read_hits_d = read_hits_q + 32'd1;
          end else begin
            stall_c       = 1'b1;
            read_misses_d = read_misses_q + 32'd1;
            state_d       = ST_RD_MISS;
            mem_req_d     = 1'b1;
            mem_we_d      = 1'b0;
            mem_addr_d    = WORD_W'({req_addr[ADDR_BITS-1:2], 2'b00});
          end
        end
      end
      ST_RD_MISS: begin
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          line_we           = 1'b1;
          valid_d[own_idx]  = 1'b1;
          mem_req_d         = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      ST_WR_THRU: begin
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          // Update only a resident line; misses do not allocate.
          line_we   = own_hit;
          line_data = (data_q[own_idx] & ~strb_mask(mem_wstrb_q))
                    | (mem_wdata_q & strb_mask(mem_wstrb_q));
          mem_req_d = 1'b0;
          state_d   = ST_WR_DONE;
        end
      end
      ST_WR_DONE: begin
        // Release the pipeline for one cycle without re-sampling the held store.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, request and counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      read_hits_q   <= '0;
      read_misses_q <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      read_hits_q   <= read_hits_d;
      read_misses_q <= read_misses_d;
      valid_q       <= valid_d;
    end
  end

  // Tag/data arrays; contents are qualified by valid_q, so no reset needed.
  always_ff @(posedge CLK) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
  end

  assign bus.stall         = stall_c & ~RESET;
  assign bus.data_read_fDM = RESET ? '0 : rdata_c;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wstrb     = mem_wstrb_q;
  assign bus.read_hits     = read_hits_q;
  assign bus.read_misses   = read_misses_q;

endmodule

// File: tb/tb_dmem_cache_responder.sv
// Self-checking bench for dmem_cache_responder: directed scenarios, randomized
// load/store/idle traffic against a word-level cache/memory model, and reset
// abandonment of an outstanding miss.
module tb_dmem_cache_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_cache_responder_if bus();

  dmem_cache_responder #(.INDEX_BITS(6), .ADDR_BITS(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing memory (written with what the DUT puts on the bus) and the reference
  // memory (written with what a store should do). Unwritten words are seeded.
  logic [31:0] bmem    [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] seed_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] bmem_rd(input int unsigned w);
    return bmem.exists(w) ? bmem[w] : seed_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : seed_word(w);
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [3:0] strb,
                                             input logic [31:0] lanes);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[3-b]) w = (w & ~(32'hFF << (8*(3-b)))) | (lanes & (32'hFF << (8*(3-b))));
    end
    return w;
  endfunction

  // Store semantics written byte by byte: byte off+j takes source byte N-1-j.
  task automatic model_store(input logic [1:0] off, input logic [1:0] size, input logic [31:0] data,
                             output logic [3:0] strb, output logic [31:0] lanes);
    int n;
    n = (size == 2'd0) ? 4 : int'(size);
    strb  = '0;
    lanes = '0;
    for (int j = 0; j < n; j++) begin
      int b;
      b = int'(off) + j;
      if (b < 4) begin
        strb[3-b] = 1'b1;
        lanes = lanes | (((data >> (8*(n-1-j))) & 32'hFF) << (8*(3-b)));
      end
    end
  endtask

  // Reference cache directory: 64 one-word lines, tag = word address / 64.
  bit          rv [64];
  int unsigned rt [64];
  logic [31:0] exp_hits, exp_misses;

  function automatic bit ref_hit(input int unsigned w);
    return rv[w % 64] && (rt[w % 64] == w / 64);
  endfunction

  // Memory responder: random or forced latency, one-cycle ack pulse.
  int          force_lat = -1;
  int          last_lat  = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;
  logic        seen_we;

  initial begin : mem_model
    int lat;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req === 1'b1) begin
        seen_addr  = bus.mem_addr;
        seen_we    = bus.mem_we;
        seen_wdata = bus.mem_wdata;
        seen_wstrb = bus.mem_wstrb;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        last_lat = lat;
        repeat (lat) begin @(posedge clk); #1; end
        bus.mem_ack = 1'b1;
        if (bus.mem_req === 1'b1 && seen_we)
          bmem[seen_addr >> 2] = merge_word(bmem_rd(seen_addr >> 2), seen_wstrb, seen_wdata);
        bus.mem_rdata = seen_we ? 32'h0 : bmem_rd(seen_addr >> 2);
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
      end
    end
  end

  logic [31:0] last_rd;

  // Count stalled cycles of the held request; returns once stall is low (at negedge).
  task automatic wait_unstall(input string tag, output int n);
    bit done;
    n = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.stall) begin
        n++;
        @(posedge clk); #1;
      end else begin
        done = 1;
      end
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr);
    int unsigned w;
    bit          hit;
    int          n;
    w   = addr >> 2;
    hit = ref_hit(w);
    bus.data_address_2DM = addr;
    bus.MemRead_2DM      = 1'b1;
    bus.MemWrite_2DM     = 1'b0;
    wait_unstall("rd", n);
    last_rd = bus.data_read_fDM;
    check("rd_data", last_rd, ref_rd(w));
    check("rd_stall", 32'(n), hit ? 32'd0 : 32'(last_lat + 2));
    @(posedge clk); #1;
    bus.MemRead_2DM = 1'b0;
    if (!hit) begin
      exp_misses++;
      rv[w % 64] = 1'b1;
      rt[w % 64] = w / 64;
    end
    exp_hits++;
    check("rd_hits", bus.read_hits, exp_hits);
    check("rd_misses", bus.read_misses, exp_misses);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    logic [3:0]  strb;
    logic [31:0] lanes;
    int          n;
    model_store(addr[1:0], size, data, strb, lanes);
    bus.data_address_2DM    = addr;
    bus.data_write_2DM      = data;
    bus.data_write_size_2DM = size;
    bus.MemWrite_2DM        = 1'b1;
    bus.MemRead_2DM         = $urandom_range(0, 1) == 1;
    wait_unstall("wr", n);
    check("wr_stall", 32'(n), 32'(last_lat + 2));
    check("wr_we", 32'(seen_we), 32'd1);
    check("wr_addr", seen_addr, addr & 32'hFFFF_FFFC);
    check("wr_strb", 32'(seen_wstrb), 32'(strb));
    check("wr_lanes", seen_wdata & {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}}, lanes);
    @(posedge clk); #1;
    bus.MemWrite_2DM = 1'b0;
    bus.MemRead_2DM  = 1'b0;
    ref_mem[addr >> 2] = merge_word(ref_rd(addr >> 2), strb, lanes);
    check("wr_hits", bus.read_hits, exp_hits);
    check("wr_misses", bus.read_misses, exp_misses);
  endtask

  task automatic do_idle(input logic [31:0] addr);
    int unsigned w;
    w = addr >> 2;
    bus.data_address_2DM = addr;
    @(negedge clk);
    check("idle_stall", 32'(bus.stall), 32'd0);
    check("idle_data", bus.data_read_fDM, ref_hit(w) ? ref_rd(w) : 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.data_address_2DM    = 32'h100;
    bus.data_write_2DM      = '0;
    bus.data_write_size_2DM = '0;
    bus.MemRead_2DM         = 1'b1;
    bus.MemWrite_2DM        = 1'b0;
    exp_hits   = '0;
    exp_misses = '0;
    foreach (rv[i]) begin rv[i] = 1'b0; rt[i] = 0; end

    // Reset state, with a load strobe held so stall gating is exercised.
    repeat (3) @(posedge clk);
    #3;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_rdata", bus.data_read_fDM, 32'h0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("rst_hits", bus.read_hits, 32'h0);
    check("rst_misses", bus.read_misses, 32'h0);
    bus.MemRead_2DM = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold fill of 0x100 with ack in the third request cycle.
    bmem[32'h40]    = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    force_lat = 2;
    do_read(32'h100);
    check("cold_data", last_rd, 32'hDEADBEEF);
    do_read(32'h100);
    check("hit_hits", bus.read_hits, 32'd2);

    // Byte store into the resident line, then read back the merge.
    do_write(32'h102, SZ_BYTE, 32'h0000_00AA);
    check("sb_strb", 32'(seen_wstrb), 32'h2);
    check("sb_byte", (seen_wdata >> 8) & 32'hFF, 32'hAA);
    do_read(32'h100);
    check("sb_merge", last_rd, 32'hDEADAAEF);

    // Write miss (no allocate) then alias eviction between 0x100 and 0x200.
    do_write(32'h200, SZ_WORD, 32'h1234_5678);
    do_read(32'h200);
    check("alias_miss", bus.read_misses, 32'd2);
    do_read(32'h100);
    check("evict_miss", bus.read_misses, 32'd3);
    do_write(32'h101, SZ_TRI, 32'h00C0FFEE);
    check("tri_strb", 32'(seen_wstrb), 32'h7);

    // Randomized mix over aliasing addresses.
    force_lat = -1;
    for (int i = 0; i < 300; i++) begin
      int unsigned w, op;
      logic [31:0] a;
      w  = $urandom_range(0, 3) * 64 + $urandom_range(0, 7);
      a  = 32'(w * 4 + $urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op < 4)      do_read(a);
      else if (op < 8) do_write(a, 2'($urandom_range(0, 3)), $urandom);
      else             do_idle(a);
    end

    // Reset while a read miss is outstanding; the late ack must be ignored.
    force_lat = 3;
    bus.data_address_2DM = 32'h7F0;
    bus.MemRead_2DM      = 1'b1;
    @(posedge clk); #3;
    check("rm_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rm_rst_req", 32'(bus.mem_req), 32'd0);
    check("rm_rst_stall", 32'(bus.stall), 32'd0);
    check("rm_rst_rdata", bus.data_read_fDM, 32'h0);
    check("rm_rst_misses", bus.read_misses, 32'h0);
    bus.MemRead_2DM = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("late_ack_stall", 32'(bus.stall), 32'd0);
    check("late_ack_req", 32'(bus.mem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    foreach (rv[i]) rv[i] = 1'b0;
    exp_hits   = '0;
    exp_misses = '0;
    force_lat  = 1;
    do_read(32'h100);
    check("post_rst_miss", bus.read_misses, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
